// File: rtl/rvga_dmem_resp.sv
// rvga_dmem_resp: data-memory responder for the rvga memory stage.
// Serves word/half/byte loads and stores from one 128-bit line buffer.
// On a miss, it writes back the line if dirty and then refills it over
// a valid/ready backing-memory interface.
// Ports:
//   clk, rst_n            clock, async active-low reset
//   req_*                 load/store request (valid/ready)
//   resp_*                response (valid/ready), data and error flag
//   mem_v_o/mem_ready_i   backing-memory command handshake
//   mem_we_o/addr/wdata   command contents (line write or line read)
//   mem_rv_i/mem_rdata_i  refill data pulse
module rvga_dmem_resp #(
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_v_i,
  output logic              req_ready_o,
  input  logic              req_st_i,
  input  logic [2:0]        req_funct3_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [31:0]       req_data_i,
  output logic              resp_v_o,
  input  logic              resp_ready_i,
  output logic [31:0]       resp_data_o,
  output logic              resp_err_o,
  output logic              mem_v_o,
  input  logic              mem_ready_i,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [127:0]      mem_wdata_o,
  input  logic              mem_rv_i,
  input  logic [127:0]      mem_rdata_i
);

  localparam int unsigned TAG_W = ADDR_W - 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WB,
    S_FILL_REQ,
    S_FILL_WAIT,
    S_RESP
  } state_e;

  state_e            state_q, state_d;
  logic              line_v_q, line_v_d;
  logic              dirty_q, dirty_d;
  logic [TAG_W-1:0]  tag_q, tag_d;
  logic [127:0]      line_q, line_d;
  logic              st_q, st_d;
  logic [2:0]        f3_q, f3_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdat_q, wdat_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              err_q, err_d;

  function automatic logic [31:0] load_val(input logic [127:0] line,
                                           input logic [2:0] f3,
                                           input logic [3:0] off);
    logic [31:0] w;
    w = 32'(line >> {off, 3'b000});
    case (f3)
      3'd0:    return {{24{w[7]}}, w[7:0]};
      3'd1:    return {{16{w[15]}}, w[15:0]};
      3'd4:    return {24'b0, w[7:0]};
      3'd5:    return {16'b0, w[15:0]};
      default: return w;
    endcase
  endfunction

  function automatic logic [127:0] store_line(input logic [127:0] line,
                                              input logic [2:0] f3,
                                              input logic [3:0] off,
                                              input logic [31:0] data);
    logic [31:0]  m;
    logic [127:0] msk;
    case (f3)
      3'd0:    m = 32'h0000_00FF;
      3'd1:    m = 32'h0000_FFFF;
      default: m = '1;
    endcase
    msk = {96'b0, m} << {off, 3'b000};
    return (line & ~msk) | ({96'b0, data & m} << {off, 3'b000});
  endfunction

  // Illegal funct3 or misalignment; store funct3 5 is already illegal.
  function automatic logic req_bad(input logic st, input logic [2:0] f3,
                                   input logic [1:0] a);
    logic ill, mis;
    ill = st ? (f3 > 3'd2) : (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7);
    mis = ((f3 == 3'd1 || f3 == 3'd5) && a[0]) || (f3 == 3'd2 && a != 2'b00);
    return ill || mis;
  endfunction

  always_comb begin
    state_d     = state_q;
    line_v_d    = line_v_q;
    dirty_d     = dirty_q;
    tag_d       = tag_q;
    line_d      = line_q;
    st_d        = st_q;
    f3_d        = f3_q;
    addr_d      = addr_q;
    wdat_d      = wdat_q;
    rdata_d     = rdata_q;
    err_d       = err_q;
    req_ready_o = 1'b0;
    mem_v_o     = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    case (state_q)
      S_IDLE: begin
        req_ready_o = 1'b1;
        if (req_v_i) begin
          st_d    = req_st_i;
          f3_d    = req_funct3_i;
          addr_d  = req_addr_i;
          wdat_d  = req_data_i;
          rdata_d = '0;
          err_d   = 1'b0;
          if (req_bad(req_st_i, req_funct3_i, req_addr_i[1:0])) begin
            err_d   = 1'b1;
            state_d = S_RESP;
          end else if (line_v_q && tag_q == req_addr_i[ADDR_W-1:4]) begin
            if (req_st_i) begin
              line_d  = store_line(line_q, req_funct3_i, req_addr_i[3:0], req_data_i);
              dirty_d = 1'b1;
            end else begin
              rdata_d = load_val(line_q, req_funct3_i, req_addr_i[3:0]);
            end
            state_d = S_RESP;
          end else if (dirty_q) begin
            state_d = S_WB;
          end else begin
            state_d = S_FILL_REQ;
          end
        end
      end
      S_WB: begin
        mem_v_o     = 1'b1;
        mem_we_o    = 1'b1;
        mem_addr_o  = {tag_q, 4'b0000};
        mem_wdata_o = line_q;
        if (mem_ready_i) state_d = S_FILL_REQ;
      end
      S_FILL_REQ: begin
        mem_v_o    = 1'b1;
        mem_addr_o = {addr_q[ADDR_W-1:4], 4'b0000};
        if (mem_ready_i) state_d = S_FILL_WAIT;
      end
      S_FILL_WAIT: begin
        if (mem_rv_i) begin
          tag_d    = addr_q[ADDR_W-1:4];
          line_v_d = 1'b1;
          // Refill and the pending access land in the same cycle.
          if (st_q) begin
            line_d  = store_line(mem_rdata_i, f3_q, addr_q[3:0], wdat_q);
            dirty_d = 1'b1;
          end else begin
            line_d  = mem_rdata_i;
            dirty_d = 1'b0;
            rdata_d = load_val(mem_rdata_i, f3_q, addr_q[3:0]);
          end
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        if (resp_ready_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    resp_v_o    = (state_q == S_RESP);
    resp_data_o = resp_v_o ? rdata_q : '0;
    resp_err_o  = resp_v_o & err_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      line_v_q <= 1'b0;
      dirty_q  <= 1'b0;
      tag_q    <= '0;
      line_q   <= '0;
      st_q     <= 1'b0;
      f3_q     <= '0;
      addr_q   <= '0;
      wdat_q   <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      line_v_q <= line_v_d;
      dirty_q  <= dirty_d;
      tag_q    <= tag_d;
      line_q   <= line_d;
      st_q     <= st_d;
      f3_q     <= f3_d;
      addr_q   <= addr_d;
      wdat_q   <= wdat_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

endmodule

// File: tb/tb_rvga_dmem_resp.sv
// Bench for rvga_dmem_resp: table of request vectors with a response
// scoreboard, a backing-memory responder, and hand-written miss,
// backpressure and reset sequences.
module tb_rvga_dmem_resp;

  localparam int unsigned AW = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_v_i, req_ready_o, req_st_i;
  logic [2:0]    req_funct3_i;
  logic [AW-1:0] req_addr_i;
  logic [31:0]   req_data_i;
  logic          resp_v_o, resp_ready_i, resp_err_o;
  logic [31:0]   resp_data_o;
  logic          mem_v_o, mem_ready_i, mem_we_o, mem_rv_i;
  logic [AW-1:0] mem_addr_o;
  logic [127:0]  mem_wdata_o, mem_rdata_i;

  rvga_dmem_resp #(.ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_v_i(req_v_i), .req_ready_o(req_ready_o), .req_st_i(req_st_i),
    .req_funct3_i(req_funct3_i), .req_addr_i(req_addr_i), .req_data_i(req_data_i),
    .resp_v_o(resp_v_o), .resp_ready_i(resp_ready_i),
    .resp_data_o(resp_data_o), .resp_err_o(resp_err_o),
    .mem_v_o(mem_v_o), .mem_ready_i(mem_ready_i), .mem_we_o(mem_we_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_rv_i(mem_rv_i), .mem_rdata_i(mem_rdata_i)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Backing memory responder (acts at posedge+1; main sequence at posedge+2)
  logic [127:0] backing [logic [31:0]];
  int           hold_cnt = 0;
  int           fill_lat = 0;
  int           rv_cnt   = 0;
  bit           pend_read = 0;
  logic [31:0]  pend_addr;
  bit           cmd_active = 0;
  logic         cap_we;
  logic [31:0]  cap_addr;
  logic [127:0] cap_wdata;
  int           n_rd = 0, n_wr = 0, n_vcyc = 0, rv_cyc = 0;
  logic [31:0]  wr_addr_log = '0, rd_addr_log = '0;
  logic [127:0] wr_data_log = '0;

  initial begin
    mem_ready_i = 1'b0;
    mem_rv_i    = 1'b0;
    mem_rdata_i = '0;
    forever begin
      @(posedge clk);
      #1;
      mem_ready_i = 1'b0;
      mem_rv_i    = 1'b0;
      if (!rst_n) begin
        pend_read  = 0;
        cmd_active = 0;
      end else begin
        if (pend_read) begin
          if (rv_cnt == 0) begin
            mem_rv_i    = 1'b1;
            mem_rdata_i = backing.exists(pend_addr) ? backing[pend_addr] : '0;
            pend_read   = 0;
            rv_cyc      = cyc + 1;
          end else begin
            rv_cnt--;
          end
        end
        if (mem_v_o) begin
          n_vcyc++;
          if (!cmd_active) begin
            cmd_active = 1;
            cap_we     = mem_we_o;
            cap_addr   = mem_addr_o;
            cap_wdata  = mem_wdata_o;
          end else begin
            chk("mem_we_stable", mem_we_o, cap_we);
            chk("mem_addr_stable", mem_addr_o, cap_addr);
            chk("mem_wdata_stable", mem_wdata_o, cap_wdata);
          end
          if (hold_cnt > 0) begin
            hold_cnt--;
          end else begin
            mem_ready_i = 1'b1;
            cmd_active  = 0;
            if (mem_we_o) begin
              n_wr++;
              wr_addr_log = mem_addr_o;
              wr_data_log = mem_wdata_o;
              backing[mem_addr_o] = mem_wdata_o;
            end else begin
              n_rd++;
              rd_addr_log = mem_addr_o;
              pend_addr   = mem_addr_o;
              pend_read   = 1;
              rv_cnt      = fill_lat;
            end
          end
        end
      end
    end
  end

  typedef struct {
    logic        st;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] exp_data;
    logic        exp_err;
    int          exp_rd;
    int          exp_wr;
  } vec_t;

  typedef struct packed {
    logic [31:0] d;
    logic        e;
  } exp_t;

  exp_t sb[$];

  function automatic vec_t mk(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                              input logic [31:0] data, input logic [31:0] ed, input logic ee,
                              input int rd, input int wr);
    vec_t v;
    v.st = st; v.f3 = f3; v.addr = addr; v.data = data;
    v.exp_data = ed; v.exp_err = ee; v.exp_rd = rd; v.exp_wr = wr;
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic run_req(input vec_t v, input int bp);
    int   vc0, rd0, wr0, acc, n;
    exp_t e, got;
    vc0 = n_vcyc; rd0 = n_rd; wr0 = n_wr;
    sb.push_back('{d: v.exp_data, e: v.exp_err});
    req_v_i = 1'b1; req_st_i = v.st; req_funct3_i = v.f3;
    req_addr_i = v.addr; req_data_i = v.data;
    n = 0;
    while (!req_ready_o && n < 50) begin step(); n++; end
    if (!req_ready_o) begin
      chk("req_accept_timeout", req_ready_o, 1'b1);
      req_v_i = 1'b0;
      void'(sb.pop_back());
      return;
    end
    acc = cyc + 1;
    step();
    req_v_i = 1'b0;
    n = 0;
    while (!resp_v_o && n < 100) begin step(); n++; end
    if (!resp_v_o) begin
      chk("resp_timeout", resp_v_o, 1'b1);
      void'(sb.pop_front());
      return;
    end
    if (v.exp_rd == 0 && v.exp_wr == 0) begin
      chk("hit_latency", cyc - acc + 1, 1);
      chk("no_mem_traffic", n_vcyc - vc0, 0);
    end else begin
      chk("rv_to_resp_latency", cyc - rv_cyc + 1, 1);
    end
    got = '{d: resp_data_o, e: resp_err_o};
    for (int i = 0; i < bp; i++) begin
      step();
      chk("bp_resp_v", resp_v_o, 1'b1);
      chk("bp_resp_data", resp_data_o, got.d);
      chk("bp_req_ready", req_ready_o, 1'b0);
    end
    resp_ready_i = 1'b1;
    chk("hs_req_ready", req_ready_o, 1'b0);
    step();
    resp_ready_i = 1'b0;
    chk("post_hs_resp_v", resp_v_o, 1'b0);
    e = sb.pop_front();
    chk("resp_data", got.d, e.d);
    chk("resp_err", got.e, e.e);
    chk("mem_reads", n_rd - rd0, v.exp_rd);
    chk("mem_writes", n_wr - wr0, v.exp_wr);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    vec_t vt[$];
    int   n, rd0;
    bit   spurious;

    backing[32'h100] = 128'hCAFEF00D_01234567_DE5A1234_DEADBEEF;
    backing[32'h200] = 128'h44444444_33333333_22222222_11111111;

    rst_n = 1'b0; req_v_i = 1'b0; req_st_i = 1'b0; req_funct3_i = '0;
    req_addr_i = '0; req_data_i = '0; resp_ready_i = 1'b0;
    repeat (3) step();
    chk("rst_req_ready", req_ready_o, 1'b1);
    chk("rst_resp_v", resp_v_o, 1'b0);
    chk("rst_resp_data", resp_data_o, 32'h0);
    chk("rst_resp_err", resp_err_o, 1'b0);
    chk("rst_mem_v", mem_v_o, 1'b0);
    chk("rst_mem_we", mem_we_o, 1'b0);
    chk("rst_mem_addr", mem_addr_o, 32'h0);
    chk("rst_mem_wdata", mem_wdata_o, 128'h0);
    rst_n = 1'b1;
    step();

    //          st  f3    addr       data          exp_data      err rd wr
    vt.push_back(mk(0, 3'd2, 32'h100, 32'h0,        32'hDEADBEEF, 0, 1, 0));
    vt.push_back(mk(0, 3'd0, 32'h107, 32'h0,        32'hFFFFFFDE, 0, 0, 0));
    vt.push_back(mk(0, 3'd4, 32'h107, 32'h0,        32'h000000DE, 0, 0, 0));
    vt.push_back(mk(1, 3'd0, 32'h102, 32'h000000AA, 32'h0,        0, 0, 0));
    vt.push_back(mk(0, 3'd2, 32'h100, 32'h0,        32'hDEAABEEF, 0, 0, 0));
    vt.push_back(mk(0, 3'd1, 32'h104, 32'h0,        32'h00001234, 0, 0, 0));
    vt.push_back(mk(0, 3'd1, 32'h106, 32'h0,        32'hFFFFDE5A, 0, 0, 0));
    vt.push_back(mk(0, 3'd5, 32'h106, 32'h0,        32'h0000DE5A, 0, 0, 0));
    vt.push_back(mk(0, 3'd0, 32'h104, 32'h0,        32'h00000034, 0, 0, 0));
    vt.push_back(mk(1, 3'd1, 32'h10E, 32'h12348765, 32'h0,        0, 0, 0));
    vt.push_back(mk(0, 3'd2, 32'h10C, 32'h0,        32'h8765F00D, 0, 0, 0));
    vt.push_back(mk(0, 3'd4, 32'h10F, 32'h0,        32'h00000087, 0, 0, 0));
    vt.push_back(mk(1, 3'd2, 32'h108, 32'hA5A55A5A, 32'h0,        0, 0, 0));
    vt.push_back(mk(0, 3'd2, 32'h108, 32'h0,        32'hA5A55A5A, 0, 0, 0));
    vt.push_back(mk(0, 3'd1, 32'h101, 32'h0,        32'h0,        1, 0, 0));
    vt.push_back(mk(1, 3'd2, 32'h102, 32'h12345678, 32'h0,        1, 0, 0));
    vt.push_back(mk(0, 3'd3, 32'h100, 32'h0,        32'h0,        1, 0, 0));
    vt.push_back(mk(1, 3'd5, 32'h100, 32'h12345678, 32'h0,        1, 0, 0));
    vt.push_back(mk(0, 3'd5, 32'h103, 32'h0,        32'h0,        1, 0, 0));
    vt.push_back(mk(0, 3'd7, 32'h104, 32'h0,        32'h0,        1, 0, 0));
    vt.push_back(mk(0, 3'd2, 32'h104, 32'h0,        32'hDE5A1234, 0, 0, 0));
    vt.push_back(mk(0, 3'd2, 32'h100, 32'h0,        32'hDEAABEEF, 0, 0, 0));
    foreach (vt[i]) run_req(vt[i], 0);

    // Dirty miss with command held off for 3 cycles
    hold_cnt = 3;
    run_req(mk(0, 3'd2, 32'h200, 32'h0, 32'h11111111, 0, 1, 1), 0);
    chk("wb_addr", wr_addr_log, 32'h100);
    chk("wb_byte2", wr_data_log[23:16], 8'hAA);
    chk("wb_line", wr_data_log, 128'h8765F00D_A5A55A5A_DE5A1234_DEAABEEF);
    chk("fill_addr_200", rd_addr_log, 32'h200);

    run_req(mk(0, 3'd0, 32'h203, 32'h0, 32'h00000011, 0, 0, 0), 0);
    run_req(mk(0, 3'd2, 32'h204, 32'h0, 32'h22222222, 0, 0, 0), 4);

    // Clean miss back to the written-back line
    run_req(mk(0, 3'd2, 32'h100, 32'h0, 32'hDEAABEEF, 0, 1, 0), 0);
    chk("fill_addr_100", rd_addr_log, 32'h100);

    // Reset while waiting for refill data
    fill_lat = 6;
    rd0 = n_rd;
    req_v_i = 1'b1; req_st_i = 1'b0; req_funct3_i = 3'd2;
    req_addr_i = 32'h200; req_data_i = '0;
    n = 0;
    while (!req_ready_o && n < 50) begin step(); n++; end
    step();
    req_v_i = 1'b0;
    n = 0;
    while (n_rd == rd0 && n < 50) begin step(); n++; end
    chk("rst_test_fill_cmd", n_rd - rd0, 1);
    step();
    chk("fill_wait_mem_v", mem_v_o, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("midrst_req_ready", req_ready_o, 1'b1);
    chk("midrst_resp_v", resp_v_o, 1'b0);
    chk("midrst_mem_v", mem_v_o, 1'b0);
    chk("midrst_resp_data", resp_data_o, 32'h0);
    step();
    step();
    rst_n = 1'b1;
    fill_lat = 0;
    spurious = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (resp_v_o || mem_v_o) spurious = 1;
    end
    chk("no_activity_after_rst", spurious, 1'b0);
    run_req(mk(0, 3'd2, 32'h100, 32'h0, 32'hDEAABEEF, 0, 1, 0), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
